// File: rtl/reg_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_reader_pkg
// Shared definitions for the register-file dump engine. It holds the register
// file geometry, the width of the emitted index, the index used for the
// checksum word, and the FSM state encoding.
// -----------------------------------------------------------------------------
package reg_dump_reader_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 64;
    localparam int IDX_W      = 5;
    localparam int DUMP_IDX_W = IDX_W + 1;

    // The last register index scanned, in RA width.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // The checksum word is tagged one past the last register. This is the
    // only use of the extra DumpIdx bit.
    localparam logic [DUMP_IDX_W-1:0] CHECKSUM_IDX = DUMP_IDX_W'(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_SEND     = 3'd2,
        ST_CHECKSUM = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // Widen a register pointer to a dump index. The MSB is always 0 for
    // real registers.
    function automatic logic [DUMP_IDX_W-1:0] reg_idx(input logic [IDX_W-1:0] ptr);
        return {1'b0, ptr};
    endfunction

endpackage

// File: rtl/reg_dump_reader_out_stage.sv
// -----------------------------------------------------------------------------
// dump_out_stage
// This is the output register of the dump engine on the valid/ready side.
// load_i captures a (data, index) pair and raises valid. The pair then stays
// constant until the sink accepts it. On the handshake, valid drops and the
// data and index hold their last value.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   synchronous active-low reset
//   load_i   in   capture data_i/idx_i and assert valid
//   data_i   in   word to present
//   idx_i    in   index of the word
//   ready_i  in   sink ready
//   data_o   out  held word
//   idx_o    out  held index
//   valid_o  out  word valid
//   hs_o     out  handshake this cycle (valid_o & ready_i)
// -----------------------------------------------------------------------------
module dump_out_stage
    import reg_dump_reader_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DUMP_IDX_W-1:0] idx_i,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [DUMP_IDX_W-1:0] idx_o,
    output logic                  valid_o,
    output logic                  hs_o
);

    logic [DATA_W-1:0]     data_q, data_d;
    logic [DUMP_IDX_W-1:0] idx_q,  idx_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            idx_d   = idx_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign hs_o    = valid_q & ready_i;

endmodule

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
// This is the read-only dump engine for the register file. A Start pulse walks
// RA over indices 0..NUM_REGS-1. On each CAPTURE edge it samples BusA and
// streams (index, data) words out through a valid/ready stage. The engine never
// drives the write side, so the datapath can keep writing on the falling edge
// while a dump runs. Each word shows the register as it was at that word's
// own capture edge.
//
// Optional feature (macro DUMP_CHECKSUM_EN): after the last register, the
// engine emits one extra word. Its index is NUM_REGS and its data is the XOR of
// every register word emitted in this dump. The accumulator clears on Start.
//
// Ports
//   Clk        in   clock, rising edge
//   Resetn     in   synchronous active-low reset; aborts a dump without Done
//   Start      in   one-cycle dump request, ignored unless idle
//   RA         out  register-file read select
//   BusA       in   combinational read data for RA
//   DumpData   out  emitted word
//   DumpIdx    out  index of DumpData (MSB set only for the checksum word)
//   DumpValid  out  DumpData/DumpIdx valid
//   DumpReady  in   sink ready
//   Busy       out  dump in progress
//   Done       out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------------
// IDLE     | waiting for Start, RA parked at 0
// CAPTURE  | RA = ptr; BusA is loaded into the output stage on this edge
// SEND     | word presented, waiting for DumpReady
// CHECKSUM | load the XOR accumulator as the final word (macro build only)
// FINISH   | raise Done, drop Busy, return to IDLE
// -----------------------------------------------------------------------------
module reg_dump_reader
    import reg_dump_reader_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Start,
    output logic [IDX_W-1:0]      RA,
    input  logic [DATA_W-1:0]     BusA,
    output logic [DATA_W-1:0]     DumpData,
    output logic [DUMP_IDX_W-1:0] DumpIdx,
    output logic                  DumpValid,
    input  logic                  DumpReady,
    output logic                  Busy,
    output logic                  Done
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic                  load;
    logic [DATA_W-1:0]     load_data;
    logic [DUMP_IDX_W-1:0] load_idx;
    logic                  hs;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    // Set once the checksum word is loaded. The next handshake in SEND then
    // ends the dump instead of advancing the pointer.
    logic              chk_q, chk_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_data = BusA;
        load_idx  = reg_idx(ptr_q);
`ifdef DUMP_CHECKSUM_EN
        acc_d     = acc_q;
        chk_d     = chk_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_CAPTURE;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    acc_d   = '0;
                    chk_d   = 1'b0;
`endif
                end
            end

            ST_CAPTURE: begin
                load    = 1'b1;
                state_d = ST_SEND;
`ifdef DUMP_CHECKSUM_EN
                acc_d   = acc_q ^ BusA;
`endif
            end

            ST_SEND: begin
                if (hs) begin
`ifdef DUMP_CHECKSUM_EN
                    if (chk_q) begin
                        state_d = ST_FINISH;
                    end else if (ptr_q == LAST_IDX) begin
                        state_d = ST_CHECKSUM;
                    end else begin
                        ptr_d   = ptr_q + IDX_W'(1);
                        state_d = ST_CAPTURE;
                    end
`else
                    if (ptr_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        ptr_d   = ptr_q + IDX_W'(1);
                        state_d = ST_CAPTURE;
                    end
`endif
                end
            end

`ifdef DUMP_CHECKSUM_EN
            ST_CHECKSUM: begin
                load      = 1'b1;
                load_data = acc_q;
                load_idx  = CHECKSUM_IDX;
                chk_d     = 1'b1;
                state_d   = ST_SEND;
            end
`endif

            ST_FINISH: begin
                // Done and Busy are registered, so the falling Busy and the
                // rising Done show up on the same edge.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            acc_q <= '0;
            chk_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            chk_q <= chk_d;
        end
    end
`endif

    dump_out_stage u_out (
        .clk_i   (Clk),
        .rst_ni  (Resetn),
        .load_i  (load),
        .data_i  (load_data),
        .idx_i   (load_idx),
        .ready_i (DumpReady),
        .data_o  (DumpData),
        .idx_o   (DumpIdx),
        .valid_o (DumpValid),
        .hs_o    (hs)
    );

    // RA is parked at 0 when idle. The pointer keeps its last value after a
    // dump, so it is masked here.
    assign RA   = (state_q == ST_IDLE) ? '0 : ptr_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Resetn;
    logic                  Start;
    logic [IDX_W-1:0]      RA;
    logic [DATA_W-1:0]     BusA;
    logic [DATA_W-1:0]     DumpData;
    logic [DUMP_IDX_W-1:0] DumpIdx;
    logic                  DumpValid;
    logic                  DumpReady;
    logic                  Busy;
    logic                  Done;

    logic [63:0] regs [32];

    int total = 0;
    int bad   = 0;

`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_WORDS = 33;
    localparam int BASE_DONE = 68;
`else
    localparam int EXP_WORDS = 32;
    localparam int BASE_DONE = 66;
`endif

    always #5 Clk = ~Clk;

    // Register file read port: reg 31 is hardwired to zero.
    assign BusA = (RA == 5'd31) ? 64'd0 : regs[RA];

    reg_dump_reader dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .Start     (Start),
        .RA        (RA),
        .BusA      (BusA),
        .DumpData  (DumpData),
        .DumpIdx   (DumpIdx),
        .DumpValid (DumpValid),
        .DumpReady (DumpReady),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one dump. It is entered and left 1 time unit after a rising edge.
    // Window cyc=1 is the cycle right after the edge that samples Start.
    task automatic run_dump(input int xstart_cyc, input int stall_word, input int stall_len,
                            input int wr_idx, input logic [63:0] wr_val,
                            input int abort_word, input int exp_done);
        logic [63:0] expw [33];
        logic [63:0] x;
        int nwords, stall_cnt, wr_arm, after_abort_done;
        bit done_seen, aborted;

        x = 64'd0;
        for (int k = 0; k < 32; k++) begin
            if (k == 31)          expw[k] = 64'd0;
            else if (k == wr_idx) expw[k] = wr_val;
            else                  expw[k] = 64'h1000 + 64'(k);
            x = x ^ expw[k];
        end
        expw[32] = x;

        nwords = 0; stall_cnt = 0; wr_arm = 0; done_seen = 0; aborted = 0;

        Start = 1'b1; DumpReady = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("busy_after_start", Busy, 1);
        chk("ra_after_start", RA, 0);
        chk("valid_after_start", DumpValid, 0);

        for (int cyc = 1; cyc < 400 && !done_seen; cyc++) begin
            Start     = (cyc == xstart_cyc);
            DumpReady = 1'b1;
            if (abort_word >= 0 && DumpValid && DumpIdx == abort_word) begin
                aborted = 1;
                break;
            end
            if (DumpValid && DumpIdx == stall_word && stall_cnt < stall_len) begin
                DumpReady = 1'b0;
                stall_cnt++;
                chk("stall_hold_data", DumpData, expw[stall_word]);
                chk("stall_hold_idx", DumpIdx, stall_word);
            end
            if (Done) begin
                done_seen = 1;
                chk("done_cycle", cyc, exp_done);
                chk("words_before_done", nwords, EXP_WORDS);
                chk("busy_low_with_done", Busy, 0);
            end else if (DumpValid && DumpReady) begin
                if (nwords < EXP_WORDS) begin
                    chk($sformatf("word%0d_idx", nwords), DumpIdx, nwords);
                    chk($sformatf("word%0d_data", nwords), DumpData, expw[nwords]);
                end else begin
                    chk("extra_word", nwords, EXP_WORDS - 1);
                end
                if (wr_idx > 0 && nwords == wr_idx - 1) wr_arm = 2;
                nwords++;
            end
            @(negedge Clk);
            if (wr_arm == 1) regs[wr_idx] = wr_val;
            if (wr_arm > 0) wr_arm--;
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        chk("dump_ended", done_seen | aborted, 1);

        if (done_seen) begin
            chk("done_one_cycle", Done, 0);
            chk("busy_after_done", Busy, 0);
        end
        if (aborted) begin
            chk("abort_word_reached", nwords, abort_word);
            Resetn = 1'b0;
            @(posedge Clk); #1;
            Resetn = 1'b1;
            chk("abort_valid", DumpValid, 0);
            chk("abort_busy", Busy, 0);
            chk("abort_done", Done, 0);
            chk("abort_ra", RA, 0);
            chk("abort_data", DumpData, 0);
            chk("abort_idx", DumpIdx, 0);
            after_abort_done = 0;
            for (int i = 0; i < 80; i++) begin
                @(posedge Clk); #1;
                if (Done || DumpValid || Busy) after_abort_done++;
            end
            chk("quiet_after_abort", after_abort_done, 0);
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 64'h1000 + 64'(k);
        regs[31] = 64'd0;
        Resetn = 1'b0; Start = 1'b0; DumpReady = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_valid", DumpValid, 0);
        chk("rst_data", DumpData, 0);
        chk("rst_idx", DumpIdx, 0);
        chk("rst_ra", RA, 0);

        // A ready without a valid word must not start anything.
        Resetn = 1'b1; DumpReady = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk("idle_ready_valid", DumpValid, 0);
        chk("idle_ready_busy", Busy, 0);
        chk("idle_ready_ra", RA, 0);

        // Full dump with the sink always ready, plus an extra Start mid-dump.
        run_dump(5, -1, 0, -1, 64'd0, -1, BASE_DONE);

        // Back-pressure on word 7 for 5 cycles.
        run_dump(0, 7, 5, -1, 64'd0, -1, BASE_DONE + 5);

        // A falling-edge write to reg 20 just before its capture.
        run_dump(0, -1, 0, 20, 64'hDEAD, -1, BASE_DONE);
        regs[20] = 64'h1014;

        // Extra Start, then a reset while word 10 is presented.
        run_dump(3, -1, 0, -1, 64'd0, 10, BASE_DONE);

        // The engine recovers with a clean dump after the abort.
        run_dump(0, -1, 0, -1, 64'd0, -1, BASE_DONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug/readout engine on the register-file read side. On a start pulse it walks the register indices through the RA select port, captures each 64-bit BusA value on the rising edge, and streams (index, data) words out over a valid/ready handshake to a trace sink or testbench monitor. It only reads: it never touches RW, BusW or RegWr, so it runs while the datapath continues writing on the falling edge.

## Interface
- NUM_REGS, 32: number of registers scanned (indices 0..NUM_REGS-1).
- DATA_W, 64: register width.
- IDX_W, 5: width of RA; must satisfy 2^IDX_W ≥ NUM_REGS.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Resetn  in  1  reset, synchronous, active-low.
- Start  in  1  single-cycle request to begin a dump.
- RA  out  IDX_W  register select into the register-file read port.
- BusA  in  DATA_W  combinational register data for RA.
- DumpData  out  DATA_W  captured word.
- DumpIdx  out  IDX_W+1  index of DumpData (extra bit used only by the checksum word).
- DumpValid  out  1  DumpData/DumpIdx valid.
- DumpReady  in  1  sink accepts the word when DumpValid & DumpReady.
- Busy  out  1  high from accepted Start until Done.
- Done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, CAPTURE, SEND, FINISH.
- IDLE: RA=0, Busy=0. Start=1 → CAPTURE, ptr=0, Busy=1.
- CAPTURE: RA=ptr; on the edge, latch DumpData←BusA and DumpIdx←{0,ptr}; DumpValid←1; → SEND.
- SEND: hold DumpData/DumpIdx/DumpValid stable until DumpReady. On handshake: if ptr==NUM_REGS-1 → FINISH (or CHECKSUM word under macro), else ptr←ptr+1, DumpValid←0, → CAPTURE.
- FINISH: Done=1 for exactly one cycle, Busy←0, → IDLE.
- Start outside IDLE is ignored; there is no queueing.
- Index 31 reads as zero in the register file; it is still emitted, data 0.
- Each word reflects the register value at its own CAPTURE edge; no snapshot across the whole file. A falling-edge write before the capture edge is visible.
- DumpReady with DumpValid=0 has no effect.

## Timing
- Reset (Resetn=0 at a rising edge): state=IDLE, ptr=0, RA=0, DumpData=0, DumpIdx=0, DumpValid=0, Busy=0, Done=0. Reset mid-dump aborts immediately; no Done.
- Start sampled at edge t → Busy=1 and RA=0 after t; DumpValid=1 after t+1.
- With DumpReady held high: one word every 2 cycles; full dump = 2·NUM_REGS+2 cycles from Start to Done (66 for 32; 68 with checksum).
- Back-pressure: DumpValid stays high and data stays constant for any number of cycles with DumpReady=0.
- Done at t_last+1, where t_last is the final handshake edge; Busy falls on the same edge that Done rises; Start is accepted again from the next cycle.

## Configuration
- DUMP_CHECKSUM_EN defined: after the last register, one extra word with DumpIdx=NUM_REGS and DumpData = XOR of all emitted register words; the accumulator clears on Start. Added state CHECKSUM sits between SEND and FINISH.
- Undefined: no extra word, no accumulator; DumpIdx MSB is always 0.

## Structure
- Shared package: state encoding enum (IDLE, CAPTURE, SEND, CHECKSUM, FINISH), DUMP_IDX_W = IDX_W+1, and the checksum index constant.
- Single module. The valid/ready output register is a natural sub-module `dump_out_stage` (holds data and index, asserts valid, clears on handshake).

## Test plan
- Reset/idle: Resetn=0 for 2 cycles, no Start → all outputs 0, RA=0, Busy=0.
- Full dump, sink always ready: preload reg[i]=64'h1000+i (reg31 forced 0), Start → 32 words, idx 0..31, data 0x1000..0x101E then 0; Done at cycle 66.
- Back-pressure: DumpReady=0 for 5 cycles on word 7 → word 7 data/idx held constant, no skip or duplicate; Done delayed by 5.
- Concurrent write: write reg[20]=64'hDEAD on the falling edge before idx-20 capture → emitted word 20 = 64'hDEAD.
- Start during Busy and reset at word 10 → extra Start ignored (one Done only); reset returns to IDLE with DumpValid=0 and no Done.
- DUMP_CHECKSUM_EN: same preload → 33rd word idx=32, data = XOR of 0x1000..0x101E; Done at cycle 68.
